// File: rtl/cpucmd_pkg.sv
// rtl/cpucmd_pkg.sv - shared constants, header layout and FSM states for the command framer
package cpucmd_pkg;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam int         HDR_SYNC_LSB = 24;
    localparam int         HDR_OPC_LSB  = 16;
    localparam int         HDR_SEQ_LSB  = 8;
    localparam int         FLAG_TRUNC   = 7;
    localparam int         HDR_LEN_LSB  = 0;
    localparam int         HDR_LEN_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_HEADER,
        ST_PAYLOAD,
        ST_TRAILER
    } state_t;

    function automatic logic [31:0] make_header(input logic [7:0] opc,
                                                input logic [7:0] seq,
                                                input logic       trunc,
                                                input logic [5:0] len);
        logic [31:0] h;
        h = '0;
        h[HDR_SYNC_LSB +: 8]         = SYNC_BYTE;
        h[HDR_OPC_LSB +: 8]          = opc;
        h[HDR_SEQ_LSB +: 8]          = seq;
        h[FLAG_TRUNC]                = trunc;
        h[HDR_LEN_LSB +: HDR_LEN_W]  = len;
        return h;
    endfunction

endpackage

// File: rtl/framer_buf.sv
// rtl/framer_buf.sv - simple dual-port payload buffer with one-cycle registered read
module framer_buf #(
    parameter int DW    = 32,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [5:0]    i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [5:0]    i_rd_addr,
    output logic [DW-1:0] o_rd_data
);
    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [5:0] DEPTH_A  = 6'(DEPTH);

    logic [DW-1:0] r_mem [0:DEPTH-1];
    logic [DW-1:0] r_q;

    assign o_rd_data = r_q;

    // Store an incoming beat; out-of-range addresses are ignored
    always_ff @(posedge clk) begin
        if (i_we && (i_wr_addr < DEPTH_A))
            r_mem[i_wr_addr[AW-1:0]] <= i_wr_data;
    end

    // Registered read; a same-cycle write to the read address is forwarded so
    // a single-beat message is visible the cycle after it is stored
    always_ff @(posedge clk) begin
        if (i_we && (i_wr_addr == i_rd_addr))
            r_q <= i_wr_data;
        else if (i_rd_addr < DEPTH_A)
            r_q <= r_mem[i_rd_addr[AW-1:0]];
    end

endmodule

// File: rtl/cpucmd_framer.sv
// rtl/cpucmd_framer.sv - buffers a command message and emits header, payload and checksum trailer
module cpucmd_framer
    import cpucmd_pkg::*;
#(
    parameter int FT_DATA_WIDTH = 32,
    parameter int MAX_WORDS     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     msg_valid_i,
    output logic                     msg_ready_o,
    input  logic [7:0]               msg_opcode_i,
    input  logic [FT_DATA_WIDTH-1:0] msg_data_i,
    input  logic                     msg_last_i,
    output logic [FT_DATA_WIDTH-1:0] fifo_data_o,
    output logic                     fifo_we_o,
    input  logic                     fifo_full_i,
    output logic                     frame_done_o,
    output logic                     busy_o
);
    localparam logic [5:0] MAXW = 6'(MAX_WORDS);

    state_t                   r_state, w_next;
    logic [7:0]               r_opcode, r_seq;
    logic                     r_trunc;
    logic [5:0]               r_wcnt, r_rptr, w_rd_addr, w_len;
    logic [FT_DATA_WIDTH-1:0] r_data, r_sum, w_q;
    logic [7:0]               w_opc;
    logic                     w_collecting, w_emitting, w_we, w_accept, w_store;
    logic                     w_adv, w_last_pl, w_trunc;

    assign w_collecting = (r_state == ST_IDLE) || (r_state == ST_COLLECT);
    assign w_emitting   = (r_state == ST_HEADER) || (r_state == ST_PAYLOAD) || (r_state == ST_TRAILER);
    assign w_we         = w_emitting && !fifo_full_i;
    assign w_accept     = msg_valid_i && msg_ready_o;
    assign w_store      = w_accept && (r_wcnt < MAXW);
    assign w_adv        = w_we && ((r_state == ST_HEADER) || (r_state == ST_PAYLOAD));
    // r_rptr is the index already loaded into the read register, one ahead of the output word
    assign w_last_pl    = (r_state == ST_PAYLOAD) && (r_rptr == r_wcnt);
    assign w_rd_addr    = w_adv ? (r_rptr + 6'd1) : r_rptr;

    // Header fields must include the beat accepted in this very cycle
    assign w_opc   = (r_state == ST_IDLE) ? msg_opcode_i : r_opcode;
    assign w_len   = w_store ? (r_wcnt + 6'd1) : r_wcnt;
    assign w_trunc = r_trunc || (w_accept && !w_store);

    assign msg_ready_o  = !reset && w_collecting;
    assign fifo_we_o    = w_we;
    assign fifo_data_o  = r_data;
    assign frame_done_o = w_we && (r_state == ST_TRAILER);
    assign busy_o       = (r_state != ST_IDLE);

    framer_buf #(
        .DW    (FT_DATA_WIDTH),
        .DEPTH (MAX_WORDS)
    ) u_buf (
        .clk       (clk),
        .i_we      (w_store),
        .i_wr_addr (r_wcnt),
        .i_wr_data (msg_data_i),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_q)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state: emission only advances on cycles that actually write the FIFO
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept) w_next = msg_last_i ? ST_HEADER : ST_COLLECT;
            ST_COLLECT: if (w_accept && msg_last_i) w_next = ST_HEADER;
            ST_HEADER:  if (w_we) w_next = ST_PAYLOAD;
            ST_PAYLOAD: if (w_we && w_last_pl) w_next = ST_TRAILER;
            ST_TRAILER: if (w_we) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Collection counters, output word register and running checksum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode <= '0;
            r_seq    <= '0;
            r_trunc  <= 1'b0;
            r_wcnt   <= '0;
            r_rptr   <= '0;
            r_data   <= '0;
            r_sum    <= '0;
        end else begin
            if (w_accept && (r_state == ST_IDLE)) r_opcode <= msg_opcode_i;
            if (w_store) r_wcnt <= r_wcnt + 6'd1;
            if (w_accept && !w_store) r_trunc <= 1'b1;
            r_rptr <= w_rd_addr;
            if (w_accept && msg_last_i) r_data <= make_header(w_opc, r_seq, w_trunc, w_len);
            if (w_we) r_sum <= r_sum + r_data;
            if (w_adv) r_data <= w_last_pl ? ~(r_sum + r_data) : w_q;
            if (w_we && (r_state == ST_TRAILER)) begin
                r_seq   <= r_seq + 8'd1;
                r_trunc <= 1'b0;
                r_wcnt  <= '0;
                r_rptr  <= '0;
                r_sum   <= '0;
            end
        end
    end

endmodule
